des_phase_align_ctrl: RTL and testbench

- Phase-alignment controller for the 72:576 deserializer.
- Sequences the deserializer's reset and phase-init inputs and watches one deserialized 9-bit lane word for a known training pattern.
- Sweeps all 8 phases until the pattern is stable, then holds lock and monitors for loss of lock.
- Runs on the same fast clock as the deserializer and sits between chip control registers and the deserializer.

---
 rtl/des_phase_align_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_des_phase_align_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_phase_align_ctrl.sv
// Phase-alignment controller for the 72:576 deserializer: sweeps des_phi_init until the lane word matches the training pattern.
// Optional build macro DES_ALIGN_ERRCNT_EN adds a locked-state mismatch counter (err_cnt) with clear (err_clr).
module des_phase_align_ctrl #(
  parameter int unsigned RST_CYC      = 4,
  parameter int unsigned SETTLE_WORDS = 2,
  parameter int unsigned MATCH_CNT    = 4,
  parameter int unsigned LOSS_CNT     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] pattern,
  input  logic [8:0] sample,
  output logic       des_rst,
  output logic [2:0] des_phi_init,
  output logic       locked,
  output logic       fail,
  output logic       busy
`ifdef DES_ALIGN_ERRCNT_EN
  ,
  input  logic        err_clr,
  output logic [15:0] err_cnt
`endif
);

  localparam int unsigned CW  = 4;
  localparam int unsigned WCW = 3;
  localparam int unsigned PW  = 3;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LAST = (SETTLE_WORDS == 0) ? '0 : CW'(SETTLE_WORDS - 1);
  localparam logic [CW-1:0] MATCH_LAST  = CW'(MATCH_CNT - 1);
  localparam logic [CW-1:0] LOSS_LAST   = CW'(LOSS_CNT - 1);

  localparam bit PARAMS_OK = (RST_CYC >= 1) && (RST_CYC <= 15) && (SETTLE_WORDS <= 15) &&
                             (MATCH_CNT >= 1) && (MATCH_CNT <= 15) &&
                             (LOSS_CNT >= 1) && (LOSS_CNT <= 15);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_SETTLE, S_CHECK, S_LOCKED, S_FAIL
  } state_t;

  state_t          state;
  logic [WCW-1:0]  wcnt;
  logic [CW-1:0]   rcnt;
  logic [CW-1:0]   sc;
  logic [CW-1:0]   mc;
  logic [CW-1:0]   lc;
  logic            strobe;
  logic            word_ok;

  // One deserialized word lands every 8 fast cycles after des_rst release.
  assign strobe  = (wcnt == WCW'(7));
  assign word_ok = (sample == pattern);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // des_phi_init doubles as the current sweep phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      des_rst      <= 1'b0;
      des_phi_init <= '0;
      locked       <= 1'b0;
      fail         <= 1'b0;
      busy         <= 1'b0;
      wcnt         <= '0;
      rcnt         <= '0;
      sc           <= '0;
      mc           <= '0;
      lc           <= '0;
    end else begin
      wcnt <= wcnt + WCW'(1);
      if (start) begin
        state        <= S_RESET;
        des_phi_init <= '0;
        des_rst      <= 1'b1;
        rcnt         <= '0;
        sc           <= '0;
        mc           <= '0;
        lc           <= '0;
        locked       <= 1'b0;
        fail         <= 1'b0;
        busy         <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_RESET: begin
            if (rcnt >= RST_LAST) begin
              des_rst <= 1'b0;
              wcnt    <= '0;
              sc      <= '0;
              mc      <= '0;
              state   <= (SETTLE_WORDS == 0) ? S_CHECK : S_SETTLE;
            end else begin
              rcnt <= sat_inc(rcnt);
            end
          end
          S_SETTLE: begin
            if (strobe) begin
              if (sc >= SETTLE_LAST) begin
                state <= S_CHECK;
                mc    <= '0;
              end else begin
                sc <= sat_inc(sc);
              end
            end
          end
          S_CHECK: begin
            if (strobe) begin
              if (word_ok) begin
                if (mc >= MATCH_LAST) begin
                  state  <= S_LOCKED;
                  locked <= 1'b1;
                  busy   <= 1'b0;
                  lc     <= '0;
                end else begin
                  mc <= sat_inc(mc);
                end
              end else begin
                mc <= '0;
                if (des_phi_init == PW'(7)) begin
                  state <= S_FAIL;
                  fail  <= 1'b1;
                  busy  <= 1'b0;
                end else begin
                  state        <= S_RESET;
                  des_phi_init <= des_phi_init + PW'(1);
                  des_rst      <= 1'b1;
                  rcnt         <= '0;
                end
              end
            end
          end
          S_LOCKED: begin
            if (strobe) begin
              if (word_ok) begin
                lc <= '0;
              end else if (lc >= LOSS_LAST) begin
                // Lock lost: re-sweep from phase 0.
                state        <= S_RESET;
                locked       <= 1'b0;
                busy         <= 1'b1;
                des_phi_init <= '0;
                des_rst      <= 1'b1;
                rcnt         <= '0;
                lc           <= '0;
              end else begin
                lc <= sat_inc(lc);
              end
            end
          end
          S_FAIL: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DES_ALIGN_ERRCNT_EN
  // Saturating count of mismatching words seen while locked.
  always_ff @(posedge clk) begin
    if (rst || start || err_clr) begin
      err_cnt <= '0;
    end else if ((state == S_LOCKED) && strobe && !word_ok && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

  // Illegal parameter combinations are flagged whenever reset is applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (PARAMS_OK) else $error("des_phase_align_ctrl: parameter out of range");
    end
  end

endmodule

// File: tb/tb_des_phase_align_ctrl.sv
// Bench for des_phase_align_ctrl: timeline-based reference model plus directed scenarios.
module tb_des_phase_align_ctrl;

  localparam int RST_CYC      = 4;
  localparam int SETTLE_WORDS = 2;
  localparam int MATCH_CNT    = 4;
  localparam int LOSS_CNT     = 3;

  localparam int M_IDLE   = 0;
  localparam int M_SWEEP  = 1;
  localparam int M_LOCKED = 2;
  localparam int M_FAIL   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] pattern;
  logic [8:0] sample;
  logic       des_rst;
  logic [2:0] des_phi_init;
  logic       locked;
  logic       fail;
  logic       busy;
`ifdef DES_ALIGN_ERRCNT_EN
  logic        err_clr;
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  int good_phase = 99;
  bit force_bad  = 1'b0;

  always #5 clk = ~clk;

  // Deserializer stand-in: the training word appears only at the good phase.
  assign sample = (!force_bad && (int'(des_phi_init) == good_phase)) ? pattern : 9'h000;

  des_phase_align_ctrl #(
    .RST_CYC(RST_CYC), .SETTLE_WORDS(SETTLE_WORDS), .MATCH_CNT(MATCH_CNT), .LOSS_CNT(LOSS_CNT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .sample(sample),
    .des_rst(des_rst), .des_phi_init(des_phi_init), .locked(locked), .fail(fail), .busy(busy)
`ifdef DES_ALIGN_ERRCNT_EN
    , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
  );

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: outputs derived from the elapsed time since the current phase attempt began.
  int n        = 0;
  int m_mode   = M_IDLE;
  int m_phase  = 0;
  int m_att    = 0;
  int m_nmatch = 0;
  int m_nloss  = 0;
  bit m_strobe = 1'b0;
  int m_err    = 0;

  always @(posedge clk) begin : model
    int  e;
    bit  stb;
    bit  ok;
    e   = n - m_att - RST_CYC;
    stb = ((m_mode == M_SWEEP) || (m_mode == M_LOCKED)) && (e >= 0) && ((e % 8) == 7);
    ok  = (sample == pattern);
    if (rst) begin
      m_mode  = M_IDLE;
      m_phase = 0;
      m_err   = 0;
    end else if (start) begin
      m_mode   = M_SWEEP;
      m_phase  = 0;
      m_att    = n + 1;
      m_nmatch = 0;
      m_err    = 0;
    end else begin
`ifdef DES_ALIGN_ERRCNT_EN
      if (err_clr) m_err = 0;
      else if ((m_mode == M_LOCKED) && stb && !ok && (m_err < 65535)) m_err++;
`endif
      if ((m_mode == M_SWEEP) && stb && ((e / 8 + 1) > SETTLE_WORDS)) begin
        if (ok) begin
          m_nmatch++;
          if (m_nmatch == MATCH_CNT) begin
            m_mode  = M_LOCKED;
            m_nloss = 0;
          end
        end else if (m_phase == 7) begin
          m_mode = M_FAIL;
        end else begin
          m_phase++;
          m_att    = n + 1;
          m_nmatch = 0;
        end
      end else if ((m_mode == M_LOCKED) && stb) begin
        if (ok) begin
          m_nloss = 0;
        end else begin
          m_nloss++;
          if (m_nloss == LOSS_CNT) begin
            m_mode   = M_SWEEP;
            m_phase  = 0;
            m_att    = n + 1;
            m_nmatch = 0;
          end
        end
      end
    end
    n++;
    e        = n - m_att - RST_CYC;
    m_strobe = ((m_mode == M_SWEEP) || (m_mode == M_LOCKED)) && (e >= 0) && ((e % 8) == 7);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : compare
    chk("des_rst",      int'(des_rst),      int'((m_mode == M_SWEEP) && ((n - m_att) < RST_CYC)));
    chk("des_phi_init", int'(des_phi_init), m_phase);
    chk("locked",       int'(locked),       int'(m_mode == M_LOCKED));
    chk("fail",         int'(fail),         int'(m_mode == M_FAIL));
    chk("busy",         int'(busy),         int'(m_mode == M_SWEEP));
`ifdef DES_ALIGN_ERRCNT_EN
    chk("err_cnt",      int'(err_cnt),      m_err);
`endif
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_strobe();
    int i;
    i = 0;
    while (!m_strobe && (i < 40)) begin
      @(negedge clk);
      i++;
    end
    if (!m_strobe) chk("strobe_timeout", 0, 1);
  endtask

  task automatic strobe_word(input bit bad);
    wait_strobe();
    force_bad = bad;
    @(negedge clk);
    force_bad = 1'b0;
  endtask

  // Watch a sweep from the first RESET cycle until locked or fail rises.
  task automatic sweep_watch(input int max_cyc, output int lat, output int pulses,
                             output int hi, output int phi_ok);
    bit prev;
    int t0;
    bit done;
    prev = 1'b0; pulses = 0; hi = 0; phi_ok = 0; lat = -1; done = 1'b0; t0 = n;
    for (int i = 0; (i < max_cyc) && !done; i++) begin
      if (des_rst) begin
        hi++;
        if (!prev) begin
          if (int'(des_phi_init) == pulses) phi_ok++;
          pulses++;
        end
      end
      prev = des_rst;
      if (locked || fail) begin
        lat  = n - t0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) chk("sweep_timeout", 0, 1);
  endtask

  initial begin : stim
    int lat, pulses, hi, phi_ok, guard;
    rst = 1'b1; start = 1'b0; pattern = 9'h1A5;
`ifdef DES_ALIGN_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset and idle
    repeat (20) @(negedge clk);
    chk("idle_des_rst", int'(des_rst), 0);
    chk("idle_phi", int'(des_phi_init), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_locked", int'(locked), 0);
    chk("idle_fail", int'(fail), 0);

    // Lock on phase 3
    good_phase = 3;
    pulse_start();
    sweep_watch(400, lat, pulses, hi, phi_ok);
    chk("p3_latency", lat, 136);
    chk("p3_pulses", pulses, 4);
    chk("p3_phi_seq", phi_ok, 4);
    chk("p3_rst_cycles", hi, 16);
    chk("p3_locked", int'(locked), 1);
    chk("p3_phi", int'(des_phi_init), 3);
    chk("p3_busy", int'(busy), 0);

    // No valid phase
    good_phase = 99;
    pulse_start();
    sweep_watch(400, lat, pulses, hi, phi_ok);
    chk("nf_latency", lat, 224);
    chk("nf_pulses", pulses, 8);
    chk("nf_phi_seq", phi_ok, 8);
    chk("nf_rst_cycles", hi, 32);
    chk("nf_fail", int'(fail), 1);
    chk("nf_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("nf_fail_sticky", int'(fail), 1);

    // Restart clears fail; lock at phase 5, then loss of lock
    good_phase = 5;
    pulse_start();
    chk("rs_fail_clr", int'(fail), 0);
    chk("rs_phi", int'(des_phi_init), 0);
    chk("rs_des_rst", int'(des_rst), 1);
    sweep_watch(400, lat, pulses, hi, phi_ok);
    chk("p5_latency", lat, 192);
    chk("p5_locked", int'(locked), 1);
    strobe_word(1'b1);
    strobe_word(1'b1);
    strobe_word(1'b0);
    chk("loss_hold_locked", int'(locked), 1);
    strobe_word(1'b1);
    strobe_word(1'b1);
    strobe_word(1'b1);
    chk("loss_locked", int'(locked), 0);
    chk("loss_phi", int'(des_phi_init), 0);
    chk("loss_des_rst", int'(des_rst), 1);
    chk("loss_busy", int'(busy), 1);

    // Start during CHECK at phase 4
    good_phase = 6;
    pulse_start();
    guard = 0;
    while (!((des_phi_init == 3'd4) && !des_rst) && (guard < 400)) begin
      @(negedge clk);
      guard++;
    end
    chk("mid_reach_p4", int'(des_phi_init), 4);
    strobe_word(1'b0);
    strobe_word(1'b0);
    repeat (2) @(negedge clk);
    pulse_start();
    chk("mid_start_phi", int'(des_phi_init), 0);
    chk("mid_start_des_rst", int'(des_rst), 1);

    // rst during RESET
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_des_rst", int'(des_rst), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_idle", int'(busy), 0);

`ifdef DES_ALIGN_ERRCNT_EN
    good_phase = 2;
    pulse_start();
    sweep_watch(400, lat, pulses, hi, phi_ok);
    chk("ec_latency", lat, 108);
    strobe_word(1'b1);
    strobe_word(1'b0);
    strobe_word(1'b1);
    chk("ec_count", int'(err_cnt), 2);
    chk("ec_locked", int'(locked), 1);
    wait_strobe();
    force_bad = 1'b1;
    err_clr   = 1'b1;
    @(negedge clk);
    force_bad = 1'b0;
    err_clr   = 1'b0;
    chk("ec_clear", int'(err_cnt), 0);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
